// File: rtl/branch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
//   Shared definitions for the EX-stage branch redirect controller:
//   FSM state encoding, default widths and the delay-slot nullify rule.
// ---------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

  // Default widths: PC/target address and performance counters.
  localparam int unsigned AW_DEFAULT = 32;
  localparam int unsigned CW_DEFAULT = 16;

  // FSM encoding. Kept as plain constants so legacy tools and waveform
  // viewers see stable numeric values.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  // PA-RISC delay-slot nullification. A taken branch nullifies its delay slot
  // when it jumps forward. A not-taken branch nullifies it when the branch
  // would have gone backward. Equal addresses count as backward (fwd = 0).
  function automatic logic nullify_ds(input logic n_bit,
                                      input logic jump,
                                      input logic fwd);
    return n_bit & (jump ? fwd : ~fwd);
  endfunction

endpackage : branch_redirect_ctrl_pkg

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   CW-bit up-counter that saturates at all-ones and never wraps.
//   Ports:
//     clk    in   clock
//     clr_n  in   asynchronous active-low clear
//     inc    in   increment enable for this cycle
//     cnt    out  current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: flops use non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//   Consumes the EX-stage jump decision. Registers each resolved branch and
//   drives the PC redirect to fetch over a valid/ready handshake. Flushes the
//   wrong-path fetch, computes delay-slot nullification and keeps saturating
//   branch/taken performance counters.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     ex_valid      EX holds a valid instruction
//     ex_branch     EX instruction is a branch
//     ex_jump       jump decision from the condition handler
//     ex_nullify    instruction N bit
//     ex_pc         PC of the branch
//     ex_target     resolved branch target
//     redir_ready   fetch accepts the redirect this cycle
//     redir_valid   redirect request to fetch
//     redir_pc      new fetch PC; stable while redir_valid is high
//     flush_if      squash the instruction currently in IF
//     null_ds       nullify the delay-slot instruction entering EX
//     stall_ex      hold EX while a redirect is pending
//     branch_cnt    branches resolved (saturating)
//     taken_cnt     branches taken (saturating)
//   Every output is a flop, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic          ex_branch,
  input  logic          ex_jump,
  input  logic          ex_nullify,
  input  logic [AW-1:0] ex_pc,
  input  logic [AW-1:0] ex_target,
  input  logic          redir_ready,
  output logic          redir_valid,
  output logic [AW-1:0] redir_pc,
  output logic          flush_if,
  output logic          null_ds,
  output logic          stall_ex,
  output logic [CW-1:0] branch_cnt,
  output logic [CW-1:0] taken_cnt
);

  logic [1:0]    state_d,       state_q;
  logic          redir_valid_d, redir_valid_q;
  logic [AW-1:0] redir_pc_d,    redir_pc_q;
  logic          flush_if_d,    flush_if_q;
  logic          null_ds_d,     null_ds_q;
  logic          stall_ex_d,    stall_ex_q;

  logic accept;
  logic accept_taken;
  logic fwd;

  // Branches arriving while a redirect is in flight are ignored. EX is
  // stalled during REDIRECT, so nothing real is lost.
  assign accept       = ex_valid & ex_branch & (state_q == ST_IDLE);
  assign accept_taken = accept & ex_jump;
  assign fwd          = (ex_target > ex_pc);

  // FSM next state.
  // NOTE: every signal assigned in an always_comb gets a default first;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept_taken) state_d = ST_REDIRECT;
      ST_REDIRECT: if (redir_valid_q && redir_ready) state_d = ST_DRAIN;
      ST_DRAIN:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so they
  // line up with the state they describe. flush_if also covers DRAIN, which
  // squashes the last stale fetch issued before fetch took the new PC.
  always_comb begin
    redir_valid_d = (state_d == ST_REDIRECT);
    stall_ex_d    = (state_d == ST_REDIRECT);
    flush_if_d    = (state_d != ST_IDLE);
    null_ds_d     = accept & nullify_ds(ex_nullify, ex_jump, fwd);
    redir_pc_d    = accept_taken ? ex_target : redir_pc_q;
  end

  // NOTE: reset clears only control/state flops and the small output
  // registers. An async drop of rst_n kills a pending request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_if_q    <= 1'b0;
      null_ds_q     <= 1'b0;
      stall_ex_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_if_q    <= flush_if_d;
      null_ds_q     <= null_ds_d;
      stall_ex_q    <= stall_ex_d;
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign flush_if    = flush_if_q;
  assign null_ds     = null_ds_q;
  assign stall_ex    = stall_ex_q;

  sat_counter #(.CW(CW)) u_branch_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (accept),
    .cnt   (branch_cnt)
  );

  sat_counter #(.CW(CW)) u_taken_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (accept_taken),
    .cnt   (taken_cnt)
  );

  // Upstream guarantees EX never presents a branch during DRAIN.
  a_no_branch_in_drain : assert property (
    @(posedge clk) disable iff (!rst_n)
    !((state_q == ST_DRAIN) && ex_valid && ex_branch)
  );

endmodule : branch_redirect_ctrl
